fetch_seq: RTL and testbench



---
 rtl/fetch_seq.sv | 141 ++++++++++++++
 tb/tb_fetch_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: owns the program counter, reads the two instruction
// bytes, strobes the instruction register, hands off to execution and stops on halt.
module fetch_seq #(
    parameter int          ADDR_W = 8,
    parameter logic [2:0]  HLT_OP = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [2:0]        ins,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    output logic [ADDR_W-1:0] addr,
    output logic              mem_rd,
    output logic [1:0]        fetch,
    output logic              exec_go,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD1  = 4'd1,
        S_LD1  = 4'd2,
        S_DEC  = 4'd3,
        S_RD2  = 4'd4,
        S_LD2  = 4'd5,
        S_GO   = 4'd6,
        S_WAIT = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ZERO = ADDR_W'(0);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic              mem_rd_r, mem_rd_s;
    logic [1:0]        fetch_r, fetch_s;
    logic              exec_go_r, exec_go_s;
    logic              halted_r, halted_s;

    // Next state and next program counter.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_RD1;
                else       state_s = S_IDLE;
            end
            S_RD1: begin
                if (mem_ready) state_s = S_LD1;
                else           state_s = S_RD1;
            end
            S_LD1: begin
                pc_s    = pc_r + PC_ONE;
                state_s = S_DEC;
            end
            S_DEC: begin
                if (ins == HLT_OP) state_s = S_HALT;
                else               state_s = S_RD2;
            end
            S_RD2: begin
                if (mem_ready) state_s = S_LD2;
                else           state_s = S_RD2;
            end
            S_LD2: begin
                pc_s    = pc_r + PC_ONE;
                state_s = S_GO;
            end
            S_GO: state_s = S_WAIT;
            S_WAIT: begin
                if (exec_done) begin
                    state_s = S_RD1;
                    if (pc_load) pc_s = pc_new;
                    else         pc_s = pc_r;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HALT: begin
                if (start) state_s = S_RD1;
                else       state_s = S_HALT;
            end
            default: begin
                state_s = S_IDLE;
                pc_s    = PC_ZERO;
            end
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        mem_rd_s  = 1'b0;
        fetch_s   = 2'b00;
        exec_go_s = 1'b0;
        halted_s  = 1'b0;
        case (state_s)
            S_RD1, S_RD2: mem_rd_s = 1'b1;
            S_LD1: begin
                mem_rd_s = 1'b1;
                fetch_s  = 2'b01;
            end
            S_LD2: begin
                mem_rd_s = 1'b1;
                fetch_s  = 2'b10;
            end
            S_GO:    exec_go_s = 1'b1;
            S_HALT:  halted_s  = 1'b1;
            default: mem_rd_s  = 1'b0;
        endcase
    end

    // State, program counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            pc_r      <= PC_ZERO;
            mem_rd_r  <= 1'b0;
            fetch_r   <= 2'b00;
            exec_go_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            mem_rd_r  <= mem_rd_s;
            fetch_r   <= fetch_s;
            exec_go_r <= exec_go_s;
            halted_r  <= halted_s;
        end
    end

    assign addr    = pc_r;
    assign mem_rd  = mem_rd_r;
    assign fetch   = fetch_r;
    assign exec_go = exec_go_r;
    assign halted  = halted_r;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: memory and instruction-register model around the DUT,
// cycle-by-cycle checks of addr/mem_rd/fetch/exec_go/halted against hand-derived values.
module tb_fetch_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_ready;
    logic [2:0] ins;
    logic       exec_done;
    logic       pc_load;
    logic [7:0] pc_new;
    logic [7:0] addr;
    logic       mem_rd;
    logic [1:0] fetch;
    logic       exec_go;
    logic       halted;

    logic [7:0] mem [256];
    logic [7:0] ir_r = 8'h00;

    int checks_total  = 0;
    int checks_passed = 0;

    fetch_seq #(.ADDR_W(8), .HLT_OP(3'b000)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .ins(ins),
        .exec_done(exec_done), .pc_load(pc_load), .pc_new(pc_new), .addr(addr),
        .mem_rd(mem_rd), .fetch(fetch), .exec_go(exec_go), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction register: captures the opcode byte on the fetch=01 strobe.
    always @(posedge clk) begin
        if (fetch == 2'b01) ir_r <= mem[addr];
    end
    assign ins = ir_r[7:5];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic chk(input string tag, input logic [7:0] a, input logic rd,
                       input logic [1:0] f, input logic g, input logic h);
        check_eq({tag, ".addr"},    {24'd0, addr},    {24'd0, a});
        check_eq({tag, ".mem_rd"},  {31'd0, mem_rd},  {31'd0, rd});
        check_eq({tag, ".fetch"},   {30'd0, fetch},   {30'd0, f});
        check_eq({tag, ".exec_go"}, {31'd0, exec_go}, {31'd0, g});
        check_eq({tag, ".halted"},  {31'd0, halted},  {31'd0, h});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h25; mem[8'h01] = 8'h40; mem[8'h02] = 8'h00;
        mem[8'h03] = 8'h25; mem[8'h04] = 8'h11;
        mem[8'h80] = 8'h61; mem[8'h81] = 8'h22;
        mem[8'hFF] = 8'h61;

        rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
        exec_done = 1'b0; pc_load = 1'b0; pc_new = 8'h00;
        #12 rst = 1'b0;
        #1 chk("reset", 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("idle", 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // First instruction, with an RD2 stall and ignored pc_load / early exec_done
        start = 1'b1;
        tick(); chk("rd1", 8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(); chk("ld1", 8'h00, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); chk("dec", 8'h01, 1'b0, 2'b00, 1'b0, 1'b0);
        start = 1'b0;
        tick(); chk("rd2", 8'h01, 1'b1, 2'b00, 1'b0, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall", 8'h01, 1'b1, 2'b00, 1'b0, 1'b0);
        end
        mem_ready = 1'b1; pc_load = 1'b1; pc_new = 8'h55;
        tick(); chk("ld2", 8'h01, 1'b1, 2'b10, 1'b0, 1'b0);
        pc_load = 1'b0;
        tick(); chk("go", 8'h02, 1'b0, 2'b00, 1'b1, 1'b0);
        exec_done = 1'b1;
        tick(); chk("wait", 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
        exec_done = 1'b0; pc_load = 1'b1;
        tick(); chk("wait_hold", 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
        pc_load = 1'b0; exec_done = 1'b1;
        tick(); chk("rd1_b", 8'h02, 1'b1, 2'b00, 1'b0, 1'b0);
        exec_done = 1'b0;

        // Halt opcode at address 2
        tick(); chk("ld1_b", 8'h02, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); chk("dec_b", 8'h03, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("halt", 8'h03, 1'b0, 2'b00, 1'b0, 1'b1);
        exec_done = 1'b1;
        tick(); chk("halt_hold", 8'h03, 1'b0, 2'b00, 1'b0, 1'b1);
        exec_done = 1'b0; start = 1'b1;
        tick(); chk("resume", 8'h03, 1'b1, 2'b00, 1'b0, 1'b0);
        start = 1'b0;
        tick(); chk("ld1_c", 8'h03, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); chk("dec_c", 8'h04, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("rd2_c", 8'h04, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(); chk("ld2_c", 8'h04, 1'b1, 2'b10, 1'b0, 1'b0);
        tick(); chk("go_c", 8'h05, 1'b0, 2'b00, 1'b1, 1'b0);
        exec_done = 1'b1; pc_load = 1'b1; pc_new = 8'h80;
        tick(); chk("wait_c", 8'h05, 1'b0, 2'b00, 1'b0, 1'b0);

        // Branch to 0x80
        tick(); chk("branch", 8'h80, 1'b1, 2'b00, 1'b0, 1'b0);
        exec_done = 1'b0; pc_load = 1'b0;
        tick(); chk("ld1_d", 8'h80, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); chk("dec_d", 8'h81, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("rd2_d", 8'h81, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(); chk("ld2_d", 8'h81, 1'b1, 2'b10, 1'b0, 1'b0);
        tick(); chk("go_d", 8'h82, 1'b0, 2'b00, 1'b1, 1'b0);
        exec_done = 1'b1; pc_load = 1'b1; pc_new = 8'hFF;
        tick(); chk("wait_d", 8'h82, 1'b0, 2'b00, 1'b0, 1'b0);

        // Instruction at 0xFF: operand wraps to 0x00
        tick(); chk("rd1_ff", 8'hFF, 1'b1, 2'b00, 1'b0, 1'b0);
        exec_done = 1'b0; pc_load = 1'b0;
        tick(); chk("ld1_ff", 8'hFF, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); chk("dec_wrap", 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("rd2_wrap", 8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(); chk("ld2_wrap", 8'h00, 1'b1, 2'b10, 1'b0, 1'b0);
        tick(); chk("go_wrap", 8'h01, 1'b0, 2'b00, 1'b1, 1'b0);
        exec_done = 1'b1;
        tick(); chk("wait_wrap", 8'h01, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("rd1_e", 8'h01, 1'b1, 2'b00, 1'b0, 1'b0);
        exec_done = 1'b0;
        tick(); chk("ld1_e", 8'h01, 1'b1, 2'b01, 1'b0, 1'b0);

        // Asynchronous reset in the middle of LD1
        #2 rst = 1'b1;
        #1 chk("async_rst", 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        #3 rst = 1'b0;
        tick(); chk("post_rst", 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        start = 1'b1;
        tick(); chk("restart", 8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
        start = 1'b0;
        tick(); chk("restart_ld1", 8'h00, 1'b1, 2'b01, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
